// File: rtl/sram_arb_pkg.sv
// Shared widths, state encodings and port identifiers for the external SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned A_AW    = 17;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSetup   = 2'd1;
  localparam logic [1:0] StStrobe  = 2'd2;
  localparam logic [1:0] StRecover = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sram_phy_seq.sv
// Single-halfword asynchronous SRAM access sequencer: SETUP, STROBE (1+wait states), RECOVER.
module sram_phy_seq
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               write_i,
  input  logic [SRAM_AW-1:0] addr_i,
  input  logic [SRAM_DW-1:0] wdata_i,
  input  logic [1:0]         mask_i,
  output logic               done_o,
  output logic [SRAM_DW-1:0] rdata_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [SRAM_DW-1:0] sram_dat_read_i,
  output logic [SRAM_DW-1:0] sram_dat_write_o,
  output logic               sram_dat_we_o,
  output logic               sram_cs_o,
  output logic               sram_we_o,
  output logic               sram_oe_o,
  output logic               sram_ub_o,
  output logic               sram_lb_o
);

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               write_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] wdata_q;
  logic [1:0]         mask_q;
  logic [SRAM_DW-1:0] rdata_q;
  logic               latch;
  logic               capture;
  logic               in_strobe;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSetup;
          latch   = 1'b1;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 3'd0;
      end
      StStrobe: begin
        if (cnt_q == WaitCnt) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRecover: begin
        done_o = 1'b1;
        // A back-to-back restart keeps the bus owned for the second half of a word.
        if (start_i) begin
          state_d = StSetup;
          latch   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_strobe = (state_q == StStrobe);
  assign capture   = in_strobe && (cnt_q == WaitCnt) && !write_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        write_q <= write_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        mask_q  <= mask_i;
      end
      if (capture) begin
        rdata_q <= sram_dat_read_i;
      end
    end
  end

  assign rdata_o          = rdata_q;
  assign sram_addr_o      = addr_q;
  assign sram_dat_write_o = wdata_q;
  // Data drivers stay on through RECOVER so the write data hold time is met.
  assign sram_dat_we_o    = write_q && (state_q != StIdle);
  assign sram_cs_o        = (state_q == StIdle);
  assign sram_we_o        = !(in_strobe && write_q);
  assign sram_oe_o        = !(in_strobe && !write_q);
  assign sram_ub_o        = in_strobe ? (write_q ? ~mask_q[1] : 1'b0) : 1'b1;
  assign sram_lb_o        = in_strobe ? (write_q ? ~mask_q[0] : 1'b0) : 1'b1;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the 16-bit external SRAM: round-robin grant, word split for port A,
// and response assembly.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               io_mainClk,
  input  logic               io_asyncResetn,
  input  logic               io_a_cmd_valid,
  output logic               io_a_cmd_ready,
  input  logic               io_a_cmd_write,
  input  logic [A_AW-1:0]    io_a_cmd_addr,
  input  logic [31:0]        io_a_cmd_wdata,
  input  logic [3:0]         io_a_cmd_mask,
  output logic               io_a_rsp_valid,
  output logic [31:0]        io_a_rsp_rdata,
  input  logic               io_b_cmd_valid,
  output logic               io_b_cmd_ready,
  input  logic               io_b_cmd_write,
  input  logic [SRAM_AW-1:0] io_b_cmd_addr,
  input  logic [SRAM_DW-1:0] io_b_cmd_wdata,
  input  logic [1:0]         io_b_cmd_mask,
  output logic               io_b_rsp_valid,
  output logic [SRAM_DW-1:0] io_b_rsp_rdata,
  output logic [SRAM_AW-1:0] io_sram_addr,
  input  logic [SRAM_DW-1:0] io_sram_dat_read,
  output logic [SRAM_DW-1:0] io_sram_dat_write,
  output logic               io_sram_dat_writeEnable,
  output logic               io_sram_cs,
  output logic               io_sram_we,
  output logic               io_sram_oe,
  output logic               io_sram_ub,
  output logic               io_sram_lb
);

  logic               busy_q;
  logic               launch_q;
  logic               port_q;
  logic               half_q;
  logic               last_q;
  logic               write_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         mask_q;
  logic [SRAM_DW-1:0] lo_q;
  logic               a_rsp_q;
  logic               b_rsp_q;
  logic [31:0]        a_rdata_q;
  logic [SRAM_DW-1:0] b_rdata_q;

  logic               grant_a, grant_b;
  logic               a_acc, b_acc;
  logic               hi_sel;
  logic               phy_start;
  logic               phy_done;
  logic [SRAM_DW-1:0] phy_rdata;
  logic [SRAM_AW-1:0] phy_addr;
  logic [SRAM_DW-1:0] phy_wdata;
  logic [1:0]         phy_mask;

  // On contention the port not served last wins.
  assign grant_a        = io_a_cmd_valid && (!io_b_cmd_valid || (last_q == PORT_B));
  assign grant_b        = io_b_cmd_valid && !grant_a;
  assign io_a_cmd_ready = !busy_q && grant_a;
  assign io_b_cmd_ready = !busy_q && grant_b;
  assign a_acc          = io_a_cmd_valid && io_a_cmd_ready;
  assign b_acc          = io_b_cmd_valid && io_b_cmd_ready;

  // Outside the launch cycle, a port-A start can only be the high half restarting in RECOVER.
  assign hi_sel    = (port_q == PORT_A) && !launch_q;
  assign phy_addr  = (port_q == PORT_A) ? {addr_q[SRAM_AW-1:1], hi_sel} : addr_q;
  assign phy_wdata = hi_sel ? wdata_q[31:16] : wdata_q[15:0];
  assign phy_mask  = hi_sel ? mask_q[3:2] : mask_q[1:0];
  assign phy_start = launch_q || (phy_done && (port_q == PORT_A) && !half_q);

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      busy_q    <= 1'b0;
      launch_q  <= 1'b0;
      port_q    <= PORT_B;
      half_q    <= 1'b0;
      last_q    <= PORT_B;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= 4'h0;
      lo_q      <= '0;
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rsp_q  <= 1'b0;
      b_rsp_q  <= 1'b0;
      launch_q <= a_acc || b_acc;
      if (a_acc) begin
        busy_q  <= 1'b1;
        port_q  <= PORT_A;
        last_q  <= PORT_A;
        half_q  <= 1'b0;
        write_q <= io_a_cmd_write;
        addr_q  <= {io_a_cmd_addr, 1'b0};
        wdata_q <= io_a_cmd_wdata;
        mask_q  <= io_a_cmd_mask;
      end else if (b_acc) begin
        busy_q  <= 1'b1;
        port_q  <= PORT_B;
        last_q  <= PORT_B;
        half_q  <= 1'b0;
        write_q <= io_b_cmd_write;
        addr_q  <= io_b_cmd_addr;
        wdata_q <= {16'h0000, io_b_cmd_wdata};
        mask_q  <= {2'b00, io_b_cmd_mask};
      end
      if (phy_done) begin
        if ((port_q == PORT_A) && !half_q) begin
          half_q <= 1'b1;
          lo_q   <= phy_rdata;
        end else if (port_q == PORT_A) begin
          busy_q    <= 1'b0;
          a_rsp_q   <= 1'b1;
          a_rdata_q <= write_q ? 32'h0 : {phy_rdata, lo_q};
        end else begin
          busy_q    <= 1'b0;
          b_rsp_q   <= 1'b1;
          b_rdata_q <= write_q ? 16'h0 : phy_rdata;
        end
      end
    end
  end

  assign io_a_rsp_valid = a_rsp_q;
  assign io_a_rsp_rdata = a_rdata_q;
  assign io_b_rsp_valid = b_rsp_q;
  assign io_b_rsp_rdata = b_rdata_q;

  sram_phy_seq #(
    .WAIT_STATES (WAIT_STATES)
  ) u_phy (
    .clk_i            (io_mainClk),
    .rst_ni           (io_asyncResetn),
    .start_i          (phy_start),
    .write_i          (write_q),
    .addr_i           (phy_addr),
    .wdata_i          (phy_wdata),
    .mask_i           (phy_mask),
    .done_o           (phy_done),
    .rdata_o          (phy_rdata),
    .sram_addr_o      (io_sram_addr),
    .sram_dat_read_i  (io_sram_dat_read),
    .sram_dat_write_o (io_sram_dat_write),
    .sram_dat_we_o    (io_sram_dat_writeEnable),
    .sram_cs_o        (io_sram_cs),
    .sram_we_o        (io_sram_we),
    .sram_oe_o        (io_sram_oe),
    .sram_ub_o        (io_sram_ub),
    .sram_lb_o        (io_sram_lb)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM and a bus-safety monitor.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, a_ready, a_write = 1'b0;
  logic [16:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_mask = '0;
  logic        a_rsp;
  logic [31:0] a_rdata;
  logic        b_valid = 1'b0, b_ready, b_write = 1'b0;
  logic [17:0] b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic [1:0]  b_mask = '0;
  logic        b_rsp;
  logic [15:0] b_rdata;
  logic [17:0] s_addr;
  logic [15:0] s_rd, s_wd;
  logic        s_dwe, s_cs, s_we, s_oe, s_ub, s_lb;

  always #5 clk = ~clk;

  sram_arbiter #(
    .WAIT_STATES (1)
  ) dut (
    .io_mainClk              (clk),
    .io_asyncResetn          (rst_n),
    .io_a_cmd_valid          (a_valid),
    .io_a_cmd_ready          (a_ready),
    .io_a_cmd_write          (a_write),
    .io_a_cmd_addr           (a_addr),
    .io_a_cmd_wdata          (a_wdata),
    .io_a_cmd_mask           (a_mask),
    .io_a_rsp_valid          (a_rsp),
    .io_a_rsp_rdata          (a_rdata),
    .io_b_cmd_valid          (b_valid),
    .io_b_cmd_ready          (b_ready),
    .io_b_cmd_write          (b_write),
    .io_b_cmd_addr           (b_addr),
    .io_b_cmd_wdata          (b_wdata),
    .io_b_cmd_mask           (b_mask),
    .io_b_rsp_valid          (b_rsp),
    .io_b_rsp_rdata          (b_rdata),
    .io_sram_addr            (s_addr),
    .io_sram_dat_read        (s_rd),
    .io_sram_dat_write       (s_wd),
    .io_sram_dat_writeEnable (s_dwe),
    .io_sram_cs              (s_cs),
    .io_sram_we              (s_we),
    .io_sram_oe              (s_oe),
    .io_sram_ub              (s_ub),
    .io_sram_lb              (s_lb)
  );

  logic [15:0] mem [0:1023];
  assign s_rd = (!s_cs && !s_oe) ? mem[s_addr[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!s_cs && !s_we) begin
      if (!s_lb) mem[s_addr[9:0]][7:0]  <= s_wd[7:0];
      if (!s_ub) mem[s_addr[9:0]][15:8] <= s_wd[15:8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          oe_cnt = 0;
  int          we_cnt = 0;
  logic [1:0]  oe_ublb = 2'b11;
  logic [19:0] we_log[$];
  logic        prev_oe_lo = 1'b0;
  logic        grants[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (!s_oe) begin
        oe_cnt++;
        oe_ublb = {s_ub, s_lb};
      end
      if (!s_we) begin
        we_cnt++;
        we_log.push_back({s_addr, s_ub, s_lb});
      end
      check("bus_overlap", {31'b0, s_dwe & ~s_oe}, 32'h0);
      check("rd_wr_gap", {31'b0, prev_oe_lo & s_dwe}, 32'h0);
      check("ready_excl", {31'b0, a_ready & b_ready}, 32'h0);
      prev_oe_lo = ~s_oe;
    end
  end

  always @(posedge clk) begin
    if (rst_n && a_valid && a_ready) grants.push_back(1'b0);
    if (rst_n && b_valid && b_ready) grants.push_back(1'b1);
  end

  // Call just after a negedge; returns on the negedge where the response is seen.
  task automatic access(input logic is_a, input logic wr, input logic [17:0] addr,
                        input logic [31:0] wd, input logic [3:0] mk,
                        output logic [31:0] rd, output int lat);
    int t;
    if (is_a) begin
      a_valid = 1'b1; a_write = wr; a_addr = addr[16:0]; a_wdata = wd; a_mask = mk;
    end else begin
      b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd[15:0]; b_mask = mk[1:0];
    end
    #1;
    t = 0;
    while (!(is_a ? a_ready : b_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", {31'b0, t < 50}, 32'h1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (is_a ? a_rsp : b_rsp) break;
    end
    rd = is_a ? a_rdata : {16'h0, b_rdata};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          rsp_seen;
    logic        found;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16]    = 16'hBEEF;
    mem[5]     = 16'h0505;
    mem[10'h280] = 16'hFFFF;
    mem[10'h281] = 16'hFFFF;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_strobes", {27'b0, s_cs, s_we, s_oe, s_ub, s_lb}, 32'h1f);
    check("rst_dwe", {31'b0, s_dwe}, 32'h0);
    check("rst_addr", {14'b0, s_addr}, 32'h0);
    check("rst_dat_write", {16'b0, s_wd}, 32'h0);
    check("rst_ready", {30'b0, a_ready, b_ready}, 32'h0);
    check("rst_rsp", {30'b0, a_rsp, b_rsp}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", {16'b0, b_rdata}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // B read
    oe_cnt = 0;
    oe_ublb = 2'b11;
    access(1'b0, 1'b0, 18'h00010, 32'h0, 4'h3, rd, lat);
    check("b_rd_lat", lat, 32'd5);
    check("b_rd_data", rd, 32'h0000BEEF);
    check("b_rd_oe_cycles", oe_cnt, 32'd2);
    check("b_rd_ublb", {30'b0, oe_ublb}, 32'h0);
    @(negedge clk);
    check("b_rsp_pulse", {31'b0, b_rsp}, 32'h0);
    check("b_rdata_hold", {16'b0, b_rdata}, 32'h0000BEEF);

    // A full-word write
    we_cnt = 0;
    we_log.delete();
    access(1'b1, 1'b1, 18'h00100, 32'h12345678, 4'hF, rd, lat);
    check("a_wr_lat", lat, 32'd9);
    check("a_wr_rdata", rd, 32'h0);
    check("a_wr_we_cycles", we_cnt, 32'd4);
    check("a_wr_lo_mem", {16'b0, mem[10'h200]}, 32'h5678);
    check("a_wr_hi_mem", {16'b0, mem[10'h201]}, 32'h1234);
    check("a_wr_lo_addr", {14'b0, we_log[0][19:2]}, 32'h200);
    check("a_wr_hi_addr", {14'b0, we_log[3][19:2]}, 32'h201);
    check("a_wr_ublb", {30'b0, we_log[0][1:0]}, 32'h0);

    // A write touching byte 2 only
    we_log.delete();
    access(1'b1, 1'b1, 18'h00140, 32'h12345678, 4'b0100, rd, lat);
    check("a_mask_lat", lat, 32'd9);
    check("a_mask_lo_ublb", {30'b0, we_log[0][1:0]}, 32'h3);
    check("a_mask_hi_ublb", {30'b0, we_log[2][1:0]}, 32'h2);
    check("a_mask_lo_mem", {16'b0, mem[10'h280]}, 32'hFFFF);
    check("a_mask_hi_mem", {16'b0, mem[10'h281]}, 32'hFF34);

    // A word read reassembles both halves
    access(1'b1, 1'b0, 18'h00100, 32'h0, 4'hF, rd, lat);
    check("a_rd_lat", lat, 32'd9);
    check("a_rd_data", rd, 32'h12345678);

    // B read directly followed by A write (accept in the response cycle)
    access(1'b0, 1'b0, 18'h00005, 32'h0, 4'h3, rd, lat);
    check("b_rd5_data", rd, 32'h0505);
    access(1'b1, 1'b1, 18'h00003, 32'hCAFEF00D, 4'hF, rd, lat);
    check("a_wr3_lat", lat, 32'd9);
    check("a_wr3_lo_mem", {16'b0, mem[6]}, 32'hF00D);
    check("a_wr3_hi_mem", {16'b0, mem[7]}, 32'hCAFE);

    // Reset during the write strobe
    a_valid = 1'b1; a_write = 1'b1; a_addr = 17'h00020; a_wdata = 32'hA5A5A5A5; a_mask = 4'hF;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = !s_we;
    end
    check("mid_rst_we_seen", {31'b0, found}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {29'b0, s_cs, s_we, s_oe}, 32'h7);
    check("mid_rst_dwe", {31'b0, s_dwe}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_rsp || b_rsp) rsp_seen++;
    end
    check("mid_rst_no_rsp", rsp_seen, 32'd0);

    // Both ports requesting from reset
    rst_n = 1'b0;
    @(negedge clk);
    grants.delete();
    a_valid = 1'b1; a_write = 1'b0; a_addr = 17'h00008;
    b_valid = 1'b1; b_write = 1'b0; b_addr = 18'h00010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 80 && grants.size() < 4; i++) @(negedge clk);
    check("arb_count", {31'b0, grants.size() >= 4}, 32'h1);
    check("arb_g0", {31'b0, grants[0]}, 32'h0);
    check("arb_g1", {31'b0, grants[1]}, 32'h1);
    check("arb_g2", {31'b0, grants[2]}, 32'h0);
    check("arb_g3", {31'b0, grants[3]}, 32'h1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the board's external 16-bit asynchronous SRAM (18-bit halfword address) between two requesters.
- Port A: 32-bit word-wide (CPU/bus side). Each word access is split into two halfword SRAM cycles.
- Port B: 16-bit halfword-wide (DMA / streaming side).
- Generates all SRAM strobes with a configurable number of wait states.
- Sits between the SoC and the SRAM pin/SB_IO layer in the top level.

Parameters:
- WAIT_STATES, 1, extra strobe cycles beyond the minimum one; legal range 0..7.

Ports:
- io_mainClk  in  1  system clock
- io_asyncResetn  in  1  asynchronous active-low reset
- io_a_cmd_valid  in  1  port A request
- io_a_cmd_ready  out  1  port A accept
- io_a_cmd_write  in  1  1 = write
- io_a_cmd_addr  in  17  word address
- io_a_cmd_wdata  in  32  write data
- io_a_cmd_mask  in  4  byte enables, bit0 = byte 0
- io_a_rsp_valid  out  1  one-cycle completion pulse
- io_a_rsp_rdata  out  32  read data
- io_b_cmd_valid, io_b_cmd_ready, io_b_cmd_write  in/out/in  1  as port A
- io_b_cmd_addr  in  18  halfword address
- io_b_cmd_wdata  in  16  write data
- io_b_cmd_mask  in  2  byte enables
- io_b_rsp_valid  out  1  completion pulse
- io_b_rsp_rdata  out  16  read data
- io_sram_addr  out  18  SRAM address
- io_sram_dat_read  in  16  SRAM data in
- io_sram_dat_write  out  16  SRAM data out
- io_sram_dat_writeEnable  out  1  data pin output enable
- io_sram_cs, io_sram_we, io_sram_oe, io_sram_ub, io_sram_lb  out  1 each  active-low strobes

Behaviour:
- Reset values:
  - cs/we/oe/ub/lb = 1.
  - dat_writeEnable = 0; addr = 0; dat_write = 0.
  - cmd_ready = 0; rsp_valid = 0; rdata = 0.
  - lastServed = B.
- Arbitration:
  - Only in IDLE. cmd_ready is combinational: high only for the granted port, while in IDLE.
  - If both ports are valid, the port not last served wins. If one is valid, it wins.
  - Accept = valid && ready. On accept, the command is latched and lastServed is updated.
- Per-halfword FSM: IDLE -> SETUP -> STROBE -> RECOVER.
  - SETUP (1 cycle): addr driven, cs = 0, we = oe = 1. For writes, dat_writeEnable = 1 and data is driven.
  - STROBE (WAIT_STATES+1 cycles, 3-bit counter):
    - Reads: oe = 0. dat_read is captured on the last STROBE cycle.
    - Writes: we = 0.
    - ub = ~mask[1] and lb = ~mask[0] for writes; ub = lb = 0 for reads.
  - RECOVER (1 cycle): we = oe = 1, cs = 0. Write data and dat_writeEnable are held.
    - Then, if port A's first half is done: back to SETUP for the second half.
    - Otherwise: IDLE.
- Port A word split:
  - Low half first, at {addr,0}, with mask[1:0] and wdata[15:0].
  - High half second, at {addr,1}, with mask[3:2] and wdata[31:16].
  - A half with a zero mask is still executed, with ub = lb = 1.
- Responses:
  - rsp_valid pulses exactly 1 cycle, in the first IDLE cycle after the final RECOVER.
  - rdata is valid in that cycle and holds until the next response. Write responses return rdata = 0.
- Latency, accept edge to rsp_valid:
  - Port B: W+4 cycles.
  - Port A: 2W+7 cycles.
- The next accept may occur in the same cycle as rsp_valid.
- Bus safety:
  - dat_writeEnable is never 1 while oe = 0.
  - Read-to-write always has at least one cycle with oe = 1 before dat_writeEnable rises. RECOVER guarantees this.
- Reset mid-operation: asynchronous; all outputs return to reset values immediately. The in-flight command is dropped and no rsp is issued.
- Commands arriving outside IDLE wait; valid must be held until ready.

Decomposition:
- Package sram_arb_pkg:
  - state enum (IDLE, SETUP, STROBE, RECOVER)
  - PORT_A / PORT_B constants
  - SRAM_AW = 18, SRAM_DW = 16, port A address width 17.
- Sub-module sram_phy_seq: single-halfword access sequencer (SETUP/STROBE/RECOVER, wait counter, read capture).
- Top level: arbitration, word split and response assembly.

Test Plan:
- All tests use WAIT_STATES = 1.
- B read addr 0x00010, SRAM model holds 0xBEEF:
  - oe low exactly 2 cycles, ub = lb = 0.
  - rsp_valid 5 cycles after accept, rdata = 0xBEEF.
- A write addr 0x00100, data 0x12345678, mask 1111:
  - Halfword 0x00200 gets 0x5678, then 0x00201 gets 0x1234.
  - we low 2 cycles per half; rsp_valid at 9 cycles.
- A write mask 0100:
  - First half: ub = lb = 1.
  - Second half: lb = 0, ub = 1; only byte 2 (0x34) changes in the model.
- Both valid continuously from reset:
  - Grants alternate A, B, A, B.
  - The first grant is A; no port is served twice consecutively.
- B read 0x00005 immediately followed by A write:
  - The checker confirms dat_writeEnable never overlaps oe = 0, with a ≥1-cycle gap.
- io_asyncResetn pulled low during STROBE of a write:
  - we/cs/oe go high and dat_writeEnable goes 0 without waiting for a clock edge.
  - After release, no rsp_valid occurs for the dropped command.
